// File: rtl/alu_pkg.sv
// Shared types for the ALU and its issue/writeback stage.
package alu_pkg;

    // ALU operating mode, driven on alu_mode
    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } alu_mode_e;

    // Command opcodes accepted by the issue stage
    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_LOAD = 2'd2,
        OP_CLRF = 2'd3
    } cmd_op_e;

    // Issue-stage FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } issue_state_e;

    // True for commands that need an ALU pass
    function automatic logic is_alu_op(cmd_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational two's-complement add/sub ALU with signed overflow output.
module alu
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 8
) (
    input  logic [WORD_SIZE-1:0] a_i,
    input  logic [WORD_SIZE-1:0] b_i,
    input  logic                 mode_i,
    output logic [WORD_SIZE-1:0] c_o,
    output logic                 overflow_o
);

    logic is_sub;

    // Wrap-around add or subtract; overflow when the sign of the result is impossible
    always_comb begin
        is_sub = (alu_mode_e'(mode_i) == SUB);
        if (is_sub) begin
            c_o        = a_i - b_i;
            overflow_o = (a_i[WORD_SIZE-1] != b_i[WORD_SIZE-1]) &&
                         (c_o[WORD_SIZE-1] != a_i[WORD_SIZE-1]);
        end else begin
            c_o        = a_i + b_i;
            overflow_o = (a_i[WORD_SIZE-1] == b_i[WORD_SIZE-1]) &&
                         (c_o[WORD_SIZE-1] != a_i[WORD_SIZE-1]);
        end
    end

endmodule

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file: one write port, two operand read ports, one debug read port.
module alu_regfile #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_REGS  = 4,
    parameter int RA_W      = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [RA_W-1:0]      waddr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic [RA_W-1:0]      raddr1_i,
    input  logic [RA_W-1:0]      raddr2_i,
    input  logic [RA_W-1:0]      dbg_addr_i,
    output logic [WORD_SIZE-1:0] rdata1_o,
    output logic [WORD_SIZE-1:0] rdata2_o,
    output logic [WORD_SIZE-1:0] dbg_data_o
);

    logic [WORD_SIZE-1:0] mem_q [NUM_REGS];

    // Reset clears every entry; otherwise a single write per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads are combinational with no write bypass
    assign rdata1_o   = mem_q[raddr1_i];
    assign rdata2_o   = mem_q[raddr2_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage: accepts a command, drives the ALU, retires the result
// into the register file and maintains result/status flags.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int NUM_REGS  = 4,
    parameter int RA_W      = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [RA_W-1:0]      cmd_rd,
    input  logic [RA_W-1:0]      cmd_rs1,
    input  logic [RA_W-1:0]      cmd_rs2,
    input  logic [WORD_SIZE-1:0] cmd_imm,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic                 alu_mode,
    input  logic [WORD_SIZE-1:0] alu_c,
    input  logic                 alu_overflow,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result,
    output logic                 flag_zero,
    output logic                 flag_neg,
    output logic                 flag_ovf,
    input  logic [RA_W-1:0]      dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data
);

    issue_state_e         state_q;
    logic                 ready_q;
    logic                 done_q;
    cmd_op_e              op_q;
    logic [RA_W-1:0]      rd_q;
    logic [RA_W-1:0]      rs1_q;
    logic [RA_W-1:0]      rs2_q;
    logic [WORD_SIZE-1:0] imm_q;
    logic [WORD_SIZE-1:0] res_q;
    logic                 ovf_q;
    logic [WORD_SIZE-1:0] result_q;
    logic                 zero_q;
    logic                 neg_q;
    logic                 sticky_ovf_q;

    logic                 wr_en_d;
    logic [WORD_SIZE-1:0] wr_data_d;
    logic [WORD_SIZE-1:0] rd1_data;
    logic [WORD_SIZE-1:0] rd2_data;

    alu_regfile #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_REGS  (NUM_REGS),
        .RA_W      (RA_W)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (wr_en_d),
        .waddr_i    (rd_q),
        .wdata_i    (wr_data_d),
        .raddr1_i   (rs1_q),
        .raddr2_i   (rs2_q),
        .dbg_addr_i (dbg_addr),
        .rdata1_o   (rd1_data),
        .rdata2_o   (rd2_data),
        .dbg_data_o (dbg_data)
    );

    // Writeback value and enable; CLRF never touches the register file
    always_comb begin
        wr_en_d   = (state_q == WB) && (op_q != OP_CLRF);
        wr_data_d = (op_q == OP_LOAD) ? imm_q : res_q;
    end

    // Sequencer: IDLE accepts, EXEC captures ALU output, WB retires and updates flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            sticky_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op_e'(cmd_op);
                        rd_q    <= cmd_rd;
                        rs1_q   <= cmd_rs1;
                        rs2_q   <= cmd_rs2;
                        imm_q   <= cmd_imm;
                        ready_q <= 1'b0;
                        if (is_alu_op(cmd_op_e'(cmd_op))) begin
                            state_q <= EXEC;
                        end else begin
                            state_q <= WB;
                            done_q  <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    res_q   <= alu_c;
                    ovf_q   <= alu_overflow;
                    state_q <= WB;
                    done_q  <= 1'b1;
                end
                WB: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    if (op_q == OP_CLRF) begin
                        sticky_ovf_q <= 1'b0;
                    end else begin
                        result_q <= wr_data_d;
                        zero_q   <= (wr_data_d == '0);
                        neg_q    <= wr_data_d[WORD_SIZE-1];
                        if (is_alu_op(op_q)) begin
                            sticky_ovf_q <= sticky_ovf_q | ovf_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // ALU operands are only driven while executing; zero otherwise
    always_comb begin
        if (state_q == EXEC) begin
            alu_a    = rd1_data;
            alu_b    = rd2_data;
            alu_mode = (op_q == OP_SUB);
        end else begin
            alu_a    = '0;
            alu_b    = '0;
            alu_mode = 1'b0;
        end
    end

    assign cmd_ready = ready_q;
    assign done      = done_q;
    assign result    = result_q;
    assign flag_zero = zero_q;
    assign flag_neg  = neg_q;
    assign flag_ovf  = sticky_ovf_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl driving a real alu instance.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int NR = 4;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [RW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [W-1:0]  cmd_imm;
    logic [W-1:0]  alu_a, alu_b, alu_c;
    logic          alu_mode, alu_overflow;
    logic          done;
    logic [W-1:0]  result;
    logic          flag_zero, flag_neg, flag_ovf;
    logic [RW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WORD_SIZE(W), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_c(alu_c), .alu_overflow(alu_overflow), .done(done), .result(result),
        .flag_zero(flag_zero), .flag_neg(flag_neg), .flag_ovf(flag_ovf),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    alu #(.WORD_SIZE(W)) u_alu (
        .a_i(alu_a), .b_i(alu_b), .mode_i(alu_mode), .c_o(alu_c), .overflow_o(alu_overflow)
    );

    typedef struct {
        logic [RW-1:0] rd;
        logic [W-1:0]  rdval;
        logic [W-1:0]  res;
        logic          fz, fn, fo;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m_regs [NR];
    logic [W-1:0] m_result;
    logic         m_fz, m_fn, m_fo;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_result = '0; m_fz = 1'b0; m_fn = 1'b0; m_fo = 1'b0;
    endtask

    // Drive one command, push its expected outcome, and pop/compare on retirement
    task automatic issue(input logic [1:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                         input logic [RW-1:0] rs2, input logic [W-1:0] imm, input bit hold,
                         input int gap, output int waited, output bit got_done);
        exp_t         e, q;
        logic [W-1:0] va, vb, v, ea, eb;
        logic         ovf, em;
        int           lat;
        got_done = 1'b0;
        waited   = 0;
        for (int g = 0; g < gap; g++) begin
            cmd_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({done, alu_a, alu_b, alu_mode} !== 18'd0) begin
                n_bad++;
                $display("FAIL idle_outputs: done/a/b/mode=%b/%h/%h/%b required 0", done, alu_a, alu_b, alu_mode);
            end
        end
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept: cmd_ready=%b required 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        va = m_regs[rs1]; vb = m_regs[rs2]; ovf = 1'b0; v = m_regs[rd];
        case (op)
            2'd0: begin v = va + vb; ovf = (va[W-1] == vb[W-1]) && (v[W-1] != va[W-1]); end
            2'd1: begin v = va - vb; ovf = (va[W-1] != vb[W-1]) && (v[W-1] != va[W-1]); end
            2'd2: v = imm;
            default: ;
        endcase
        if (op != 2'd3) begin
            m_regs[rd] = v; m_result = v; m_fz = (v == '0); m_fn = v[W-1];
            m_fo = m_fo | ovf;
        end else begin
            m_fo = 1'b0;
        end
        e.rd = rd; e.rdval = m_regs[rd]; e.res = m_result; e.fz = m_fz; e.fn = m_fn; e.fo = m_fo;
        sb.push_back(e);
        lat = (op < 2'd2) ? 2 : 1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (!hold) cmd_valid = 1'b0;
            n_cmp++;
            if (done !== (k == lat)) begin
                n_bad++;
                $display("FAIL done_timing: cycle %0d after accept done=%b required %b", k, done, (k == lat));
            end
            if (done === 1'b1) got_done = 1'b1;
            n_cmp++;
            if (cmd_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL busy_ready: cycle %0d cmd_ready=%b required 0", k, cmd_ready);
            end
            if (k == 1 && lat == 2) begin ea = va; eb = vb; em = (op == 2'd1); end
            else begin ea = '0; eb = '0; em = 1'b0; end
            n_cmp++;
            if ({alu_a, alu_b, alu_mode} !== {ea, eb, em}) begin
                n_bad++;
                $display("FAIL alu_drive: a/b/mode=%h/%h/%b required %h/%h/%b", alu_a, alu_b, alu_mode, ea, eb, em);
            end
        end
        q = sb.pop_front();
        dbg_addr = q.rd;
        @(negedge clk);
        n_cmp++;
        if ({result, flag_zero, flag_neg, flag_ovf} !== {q.res, q.fz, q.fn, q.fo}) begin
            n_bad++;
            $display("FAIL retire_flags: result/z/n/o=%h/%b/%b/%b required %h/%b/%b/%b",
                     result, flag_zero, flag_neg, flag_ovf, q.res, q.fz, q.fn, q.fo);
        end
        n_cmp++;
        if (dbg_data !== q.rdval) begin
            n_bad++;
            $display("FAIL retire_reg: r%0d=%h required %h", q.rd, dbg_data, q.rdval);
        end
        n_cmp++;
        if ({cmd_ready, done, alu_a, alu_b, alu_mode} !== {1'b1, 18'd0}) begin
            n_bad++;
            $display("FAIL post_idle: ready/done/a/b/mode=%b/%b/%h/%h/%b required 1/0/0/0/0",
                     cmd_ready, done, alu_a, alu_b, alu_mode);
        end
    endtask

    task automatic check_all_regs_zero(input string tag);
        for (int i = 0; i < NR; i++) begin
            dbg_addr = RW'(i);
            #1;
            n_cmp++;
            if (dbg_data !== '0) begin
                n_bad++;
                $display("FAIL %s_reg%0d: %h required 00", tag, i, dbg_data);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_imm = '0; dbg_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if ({cmd_ready, done, result, flag_zero, flag_neg, flag_ovf} !== {1'b1, 12'd0}) begin
            n_bad++;
            $display("FAIL reset_state: ready/done/result/z/n/o=%b/%b/%h/%b/%b/%b required 1/0/00/0/0/0",
                     cmd_ready, done, result, flag_zero, flag_neg, flag_ovf);
        end
        check_all_regs_zero("reset");
    endtask

    task automatic test_add_basic();
        int w; bit d;
        issue(2'd2, 2'd0, 2'd0, 2'd0, 8'd5, 1'b0, 0, w, d);
        issue(2'd2, 2'd1, 2'd0, 2'd0, 8'hF6, 1'b0, 0, w, d);
        issue(2'd0, 2'd2, 2'd0, 2'd1, 8'd0, 1'b0, 0, w, d);
        dbg_addr = 2'd2; #1;
        n_cmp++;
        if ({dbg_data, flag_neg, flag_zero, flag_ovf} !== {8'hFB, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL add_basic: r2/n/z/o=%h/%b/%b/%b required fb/1/0/0", dbg_data, flag_neg, flag_zero, flag_ovf);
        end
    endtask

    task automatic test_overflow_clrf();
        int w; bit d;
        issue(2'd2, 2'd0, 2'd0, 2'd0, 8'd127, 1'b0, 0, w, d);
        issue(2'd2, 2'd1, 2'd0, 2'd0, 8'd1, 1'b0, 0, w, d);
        issue(2'd0, 2'd2, 2'd0, 2'd1, 8'd0, 1'b0, 0, w, d);
        dbg_addr = 2'd2; #1;
        n_cmp++;
        if ({dbg_data, flag_ovf} !== {8'h80, 1'b1}) begin
            n_bad++;
            $display("FAIL add_ovf: r2/o=%h/%b required 80/1", dbg_data, flag_ovf);
        end
        issue(2'd1, 2'd3, 2'd0, 2'd0, 8'd0, 1'b0, 0, w, d);
        dbg_addr = 2'd3; #1;
        n_cmp++;
        if ({dbg_data, flag_zero, flag_ovf} !== {8'h00, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL sub_zero: r3/z/o=%h/%b/%b required 00/1/1", dbg_data, flag_zero, flag_ovf);
        end
        issue(2'd3, 2'd3, 2'd0, 2'd0, 8'd0, 1'b0, 0, w, d);
        dbg_addr = 2'd3; #1;
        n_cmp++;
        if ({dbg_data, flag_zero, flag_ovf} !== {8'h00, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL clrf: r3/z/o=%h/%b/%b required 00/1/0", dbg_data, flag_zero, flag_ovf);
        end
    endtask

    task automatic test_sub_wrap();
        int w; bit d;
        issue(2'd2, 2'd0, 2'd0, 2'd0, 8'h80, 1'b0, 0, w, d);
        issue(2'd2, 2'd1, 2'd0, 2'd0, 8'd1, 1'b0, 0, w, d);
        issue(2'd1, 2'd0, 2'd0, 2'd1, 8'd0, 1'b0, 0, w, d);
        dbg_addr = 2'd0; #1;
        n_cmp++;
        if ({dbg_data, flag_ovf} !== {8'h7F, 1'b1}) begin
            n_bad++;
            $display("FAIL sub_wrap: r0/o=%h/%b required 7f/1", dbg_data, flag_ovf);
        end
    endtask

    task automatic test_back_to_back();
        int w, pulses; bit d;
        logic [RW-1:0] rds [4];
        logic [RW-1:0] s1s [4];
        logic [RW-1:0] s2s [4];
        rds = '{2'd1, 2'd2, 2'd3, 2'd0};
        s1s = '{2'd0, 2'd1, 2'd2, 2'd3};
        s2s = '{2'd0, 2'd0, 2'd1, 2'd3};
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            issue(2'd0, rds[i], s1s[i], s2s[i], 8'd0, 1'b1, 0, w, d);
            if (d) pulses++;
            n_cmp++;
            if (w != 0) begin
                n_bad++;
                $display("FAIL b2b_ready: cmd %0d waited %0d cycles required 0", i, w);
            end
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (pulses != 4) begin
            n_bad++;
            $display("FAIL b2b_done_count: %0d pulses required 4", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int w; bit d;
        issue(2'd2, 2'd0, 2'd0, 2'd0, 8'd3, 1'b0, 0, w, d);
        issue(2'd2, 2'd1, 2'd0, 2'd0, 8'd4, 1'b0, 0, w, d);
        cmd_op = 2'd0; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if ({alu_a, alu_b} !== {8'd3, 8'd4}) begin
            n_bad++;
            $display("FAIL mid_exec: a/b=%h/%h required 03/04", alu_a, alu_b);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if ({cmd_ready, done, result, flag_zero, flag_neg, flag_ovf} !== {1'b1, 12'd0}) begin
            n_bad++;
            $display("FAIL mid_reset_state: ready/done/result/z/n/o=%b/%b/%h/%b/%b/%b required 1/0/00/0/0/0",
                     cmd_ready, done, result, flag_zero, flag_neg, flag_ovf);
        end
        check_all_regs_zero("mid_reset");
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_done: done=%b required 0", done);
        end
        check_all_regs_zero("mid_reset_late");
    endtask

    task automatic test_random();
        int w; bit d;
        for (int i = 0; i < 1000; i++) begin
            issue(2'($urandom_range(0, 3)), RW'($urandom_range(0, NR - 1)),
                  RW'($urandom_range(0, NR - 1)), RW'($urandom_range(0, NR - 1)),
                  W'($urandom), 1'b0, int'($urandom_range(0, 2)), w, d);
        end
        for (int i = 0; i < NR; i++) begin
            dbg_addr = RW'(i); #1;
            n_cmp++;
            if (dbg_data !== m_regs[i]) begin
                n_bad++;
                $display("FAIL random_final_r%0d: %h required %h", i, dbg_data, m_regs[i]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_basic();
        test_overflow_clrf();
        test_sub_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
